// File: rtl/sgf_divider_seq.sv
// sgf_divider_seq: sequential radix-2 restoring significand divider, one quotient bit per clock.
// Optional SGF_DIV_EARLY_TERM_EN ends the run once the remainder and the unused dividend bits are zero.
module sgf_divider_seq #(
    parameter int W_Sgf = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [W_Sgf:0]       Data_A,
    input  logic [W_Sgf:0]       Data_B,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [2*W_Sgf+1:0]   Quotient,
    output logic [W_Sgf:0]       Remainder,
    output logic                 Sticky,
    output logic                 Div_Zero
);
    localparam int N  = 2*W_Sgf+2;
    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [N-1:0]    dvd, dvd_n, q, q_n, q_fin;
    logic [W_Sgf:0]  b, rem, rem_n;
    logic [W_Sgf+1:0] trial;
    logic [CW-1:0]   cnt;
    logic            ge, fin, accept, bzero;

    assign ready_o = state != RUN;
    assign accept  = ready_o && start_i;
    assign bzero   = Data_B == '0;

    // One restoring step: the partial remainder needs one extra bit before the compare.
    always_comb begin
        trial = {rem, dvd[N-1]};
        ge    = trial >= {1'b0, b};
        rem_n = (W_Sgf+1)'(ge ? trial - {1'b0, b} : trial);
        dvd_n = dvd << 1;
        q_n   = (q << 1) | N'(ge);
`ifdef SGF_DIV_EARLY_TERM_EN
        fin   = cnt == CW'(N-1) || (rem_n == '0 && dvd_n == '0);
        q_fin = q_n << (CW'(N-1) - cnt);
`else
        fin   = cnt == CW'(N-1);
        q_fin = q_n;
`endif
    end

    always_comb begin
        state_n = accept ? (bzero ? DONE : RUN) : (state == RUN && fin) ? DONE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd       <= '0;
            b         <= '0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
            valid_o   <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            Sticky    <= 1'b0;
            Div_Zero  <= 1'b0;
        end else if (accept) begin
            dvd       <= {Data_A, {(W_Sgf+1){1'b0}}};
            b         <= Data_B;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
            valid_o   <= bzero;
            Quotient  <= bzero ? '1 : '0;
            Remainder <= '0;
            Sticky    <= 1'b0;
            Div_Zero  <= bzero;
        end else if (state == RUN) begin
            dvd <= dvd_n;
            rem <= rem_n;
            q   <= q_n;
            cnt <= cnt + 1'b1;
            if (fin) begin
                valid_o   <= 1'b1;
                Quotient  <= q_fin;
                Remainder <= rem_n;
                Sticky    <= |rem_n;
            end
        end
    end
endmodule

// File: tb/tb_sgf_divider_seq.sv
// tb_sgf_divider_seq: random and directed checks of sgf_divider_seq against an arithmetic model.
module tb_sgf_divider_seq;
    localparam int W = 23;
    localparam int N = 2*W+2;

    logic clk = 0, rst = 1, start_i = 0;
    logic [W:0] Data_A = 0, Data_B = 0;
    logic ready_o, valid_o, Sticky, Div_Zero;
    logic [N-1:0] Quotient;
    logic [W:0] Remainder;
    int ncmp = 0, nerr = 0;
    logic go = 0;

    sgf_divider_seq #(.W_Sgf(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .Data_A(Data_A), .Data_B(Data_B),
        .ready_o(ready_o), .valid_o(valid_o), .Quotient(Quotient), .Remainder(Remainder),
        .Sticky(Sticky), .Div_Zero(Div_Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int lat(input logic [W:0] a, input logic [W:0] b);
        longint unsigned d = longint'(a) << (W+1);
`ifdef SGF_DIV_EARLY_TERM_EN
        for (int k = 1; k <= N; k++)
            if (((d >> (N-k)) % longint'(b)) == 0 && (d % (64'd1 << (N-k))) == 0) return k;
`endif
        return N + 0*int'(d[0]);
    endfunction

    // Reference model: timeline and results from plain arithmetic.
    logic m_busy, m_valid, m_dz, m_known, m_s;
    logic [N-1:0] m_q, p_q;
    logic [W:0] m_r, p_r;
    int m_left;
    wire m_ready = !m_busy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_valid <= 0; m_dz <= 0; m_known <= 1;
            m_q <= 0; m_r <= 0; m_s <= 0; m_left <= 0;
        end else if (m_ready && start_i) begin
            m_dz <= Data_B == 0;
            if (Data_B == 0) begin
                m_valid <= 1; m_known <= 1; m_q <= '1; m_r <= 0; m_s <= 0;
            end else begin
                m_valid <= 0; m_known <= 0; m_busy <= 1;
                m_left <= lat(Data_A, Data_B);
                p_q <= N'((longint'(Data_A) << (W+1)) / longint'(Data_B));
                p_r <= (W+1)'((longint'(Data_A) << (W+1)) % longint'(Data_B));
            end
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 0; m_valid <= 1; m_known <= 1;
                m_q <= p_q; m_r <= p_r; m_s <= p_r != 0;
            end
        end
    end

    always @(negedge clk) if (go) begin
        chk("ready", ready_o, m_ready);
        chk("valid", valid_o, m_valid);
        chk("div_zero", Div_Zero, m_dz);
        if (m_known) begin
            chk("quotient", Quotient, m_q);
            chk("remainder", Remainder, m_r);
            chk("sticky", Sticky, m_s);
        end
    end

    task automatic start_op(input logic [W:0] a, input logic [W:0] b);
        @(negedge clk);
        Data_A = a; Data_B = b; start_i = 1;
        @(negedge clk);
        start_i = 0;
    endtask

    task automatic wait_valid(output int e);
        e = 0;
        while (!valid_o && e < 300) begin
            @(negedge clk);
            e++;
        end
        chk("valid_timeout", valid_o, 1);
    endtask

    int e;
    logic [W:0] ra, rb;

    initial begin
        #3 rst = 0;
        go = 1;
        #20 rst = 1;
        @(negedge clk);
        chk("reset_ready", ready_o, 1);
        chk("reset_valid", valid_o, 0);

        start_op(24'h800000, 24'h800000);
        wait_valid(e);
`ifdef SGF_DIV_EARLY_TERM_EN
        chk("lat_1_0", e, 24);
`else
        chk("lat_1_0", e, 48);
`endif
        chk("lit_q_1_0", Quotient, 48'h000001000000);
        chk("lit_r_1_0", Remainder, 0);

        start_op(24'hC00000, 24'h800000);
        wait_valid(e);
        chk("lit_q_1_5", Quotient, 48'h000001800000);
        chk("lit_s_1_5", Sticky, 0);

        start_op(24'h800000, 24'hC00000);
        wait_valid(e);
        chk("lat_2_3", e, 48);
        chk("lit_q_2_3", Quotient, 48'h000000AAAAAA);
        chk("lit_r_2_3", Remainder, 24'h800000);
        chk("lit_s_2_3", Sticky, 1);

        start_op(24'h123456, 24'h000000);
        wait_valid(e);
        chk("lat_dz", e, 0);
        chk("lit_q_dz", Quotient, 48'hFFFFFFFFFFFF);
        chk("lit_dz", Div_Zero, 1);

        start_op(24'h900000, 24'hA00000);
        chk("dz_cleared", Div_Zero, 0);
        repeat (9) @(negedge clk);
        Data_A = 24'hFFFFFF; Data_B = 24'h800001; start_i = 1;
        @(negedge clk);
        start_i = 0;
        chk("ready_run", ready_o, 0);
        wait_valid(e);
        chk("mid_change_q", Quotient, N'((64'h900000 << 24) / 64'hA00000));

        start_op(24'hFEDCBA, 24'h876543);
        repeat (19) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_q", Quotient, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        @(negedge clk);
        rst = 1;
        start_op(24'hFEDCBA, 24'h876543);
        wait_valid(e);
        chk("post_rst_lat", e, lat(24'hFEDCBA, 24'h876543));

        start_op(24'h000000, 24'h800000);
        wait_valid(e);
        chk("a0_q", Quotient, 0);
        chk("a0_lat", e, lat(24'h000000, 24'h800000));

        for (int i = 0; i < 60; i++) begin
            ra = $urandom_range(0, 9) == 0 ? 24'h0 : (W+1)'($urandom) | ($urandom_range(0, 3) != 0 ? 24'h800000 : 24'h0);
            rb = $urandom_range(0, 7) == 0 ? 24'h0 : (W+1)'($urandom) | ($urandom_range(0, 3) != 0 ? 24'h800000 : 24'h1);
            start_op(ra, rb);
            wait_valid(e);
            chk("rand_lat", e, rb == 0 ? 0 : lat(ra, rb));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
